// File: rtl/sample_reassembler.sv
// Purpose: re-pair low/high byte lanes from two UART receivers into SAMPLE_SIZE-bit samples.
// Latency: one cycle from the second byte of a pair being accepted to o_valid.
// Backpressure: o_ready_x drops only when that lane FIFO is full; i_ready low holds the output register.
//
// Ports:
//   i_clock, i_reset           clock, synchronous active-high reset
//   i_data_l/i_valid_l/o_ready_l  low-byte lane (sample bits [DATA_SIZE-1:0])
//   i_data_h/i_valid_h/o_ready_h  high-byte lane (sample bits [SAMPLE_SIZE-1:DATA_SIZE])
//   o_sample/o_valid/i_ready   reassembled sample, valid/ready handshake
//   o_format_err               pulse: loaded high byte had nonzero unused bits
//   o_desync                   pulse: lanes flushed after the stall timeout
//   o_overflow                 sticky: a byte was offered to a full lane FIFO
//   o_count                    samples handed off, wrapping

// Purpose: small lane FIFO with clear; storage is not reset.
// Latency: pushed entry visible on rd_dat the cycle after the push.
// Backpressure: caller must not push when full or pop when empty; clear wins over push/pop.
module sample_reassembler_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] wr_dat,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d  = mem_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clear) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = wr_dat;
        wptr_d        = wptr_q + AW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rptr_q];
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (AW+1)'(DEPTH));
endmodule

module sample_reassembler #(
  parameter int DATA_SIZE   = 8,
  parameter int SAMPLE_SIZE = 14,
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 65535,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [DATA_SIZE-1:0]   i_data_l,
  input  logic                   i_valid_l,
  output logic                   o_ready_l,
  input  logic [DATA_SIZE-1:0]   i_data_h,
  input  logic                   i_valid_h,
  output logic                   o_ready_h,
  output logic [SAMPLE_SIZE-1:0] o_sample,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic                   o_format_err,
  output logic                   o_desync,
  output logic                   o_overflow,
  output logic [COUNT_WIDTH-1:0] o_count
);
  localparam int HW = SAMPLE_SIZE - DATA_SIZE;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLUSH} state_t;

  state_t                 state_q, state_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic                   rdy_en_q, rdy_en_d;
  logic [SAMPLE_SIZE-1:0] sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   fmt_q, fmt_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [DATA_SIZE-1:0] rd_l, rd_h;
  logic empty_l, empty_h, full_l, full_h;
  logic push_l, push_h, pop, flush, one_ne, out_free;

  // Ready is held low until the first cycle after reset releases.
  assign o_ready_l = rdy_en_q && !full_l;
  assign o_ready_h = rdy_en_q && !full_h;
  assign push_l    = i_valid_l && o_ready_l;
  assign push_h    = i_valid_h && o_ready_h;

  assign flush    = (state_q == ST_FLUSH);
  assign one_ne   = empty_l ^ empty_h;
  assign out_free = !valid_q || i_ready;
  // No pairing in the flush cycle: both lanes are being discarded.
  assign pop      = !empty_l && !empty_h && out_free && !flush;

  sample_reassembler_fifo #(.W(DATA_SIZE), .DEPTH(DEPTH)) u_fifo_l (
    .clk(i_clock), .rst(i_reset), .push(push_l), .pop(pop), .clear(flush),
    .wr_dat(i_data_l), .rd_dat(rd_l), .empty(empty_l), .full(full_l)
  );

  sample_reassembler_fifo #(.W(DATA_SIZE), .DEPTH(DEPTH)) u_fifo_h (
    .clk(i_clock), .rst(i_reset), .push(push_h), .pop(pop), .clear(flush),
    .wr_dat(i_data_h), .rd_dat(rd_h), .empty(empty_h), .full(full_h)
  );

  // Output register, status and counters.
  always_comb begin
    rdy_en_d = 1'b1;
    sample_d = sample_q;
    valid_d  = valid_q;
    fmt_d    = 1'b0;
    ovf_d    = ovf_q || (i_valid_l && full_l) || (i_valid_h && full_h);
    count_d  = count_q + COUNT_WIDTH'(valid_q && i_ready);
    if (pop) begin
      sample_d = {rd_h[HW-1:0], rd_l};
      valid_d  = 1'b1;
      fmt_d    = |rd_h[DATA_SIZE-1:HW];
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Stall timeout: counts cycles where exactly one lane holds data.
  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      ST_IDLE: begin
        tcnt_d = '0;
        if (one_ne) begin
          // The cycle that detects the imbalance is the first waiting cycle.
          state_d = ST_WAIT;
          tcnt_d  = TW'(1);
        end
      end
      ST_WAIT: begin
        if (!one_ne) begin
          state_d = ST_IDLE;
          tcnt_d  = '0;
        end else if (tcnt_q == TW'(TIMEOUT - 1)) begin
          state_d = ST_FLUSH;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
      default: begin
        state_d = ST_IDLE;
        tcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      tcnt_q   <= '0;
      rdy_en_q <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      fmt_q    <= 1'b0;
      ovf_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      rdy_en_q <= rdy_en_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      fmt_q    <= fmt_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
    end
  end

  assign o_sample     = sample_q;
  assign o_valid      = valid_q;
  assign o_format_err = fmt_q;
  assign o_desync     = flush;
  assign o_overflow   = ovf_q;
  assign o_count      = count_q;
endmodule

// File: doc/sample_reassembler.md
Name: sample_reassembler

Overview:
- Receive-side counterpart of the split-byte sample transmit path: sampler → uart_tx on a low-byte lane and a high-byte lane.
- Consumes the two byte streams delivered by a pair of UART receivers and re-pairs them into 14-bit samples.
- Applies a stall timeout to resynchronise after lost bytes, flags overflow and format errors, and presents samples on a valid/ready output.
- Used in loopback/self-test builds and in the host-side capture FPGA.

Parameters:
- DATA_SIZE, 8, byte width of each lane.
- SAMPLE_SIZE, 14, reassembled sample width; high lane contributes SAMPLE_SIZE-DATA_SIZE LSBs.
- DEPTH, 4, per-lane FIFO depth (power of two, ≥2).
- TIMEOUT, 65535, cycles one lane may hold data while the other is empty before flush.
- COUNT_WIDTH, 16, width of sample counter.

Ports:
- i_clock  in  1  system clock (sys_clock domain).
- i_reset  in  1  synchronous, active-high reset.
- i_data_l  in  DATA_SIZE  low-byte lane data.
- i_valid_l  in  1  low-byte lane valid.
- o_ready_l  out  1  low lane FIFO not full.
- i_data_h  in  DATA_SIZE  high-byte lane data.
- i_valid_h  in  1  high-byte lane valid.
- o_ready_h  out  1  high lane FIFO not full.
- o_sample  out  SAMPLE_SIZE  reassembled sample {h[5:0], l[7:0]}.
- o_valid  out  1  sample valid.
- i_ready  in  1  downstream accept.
- o_format_err  out  1  one-cycle pulse: popped high byte had nonzero unused bits [7:6].
- o_desync  out  1  one-cycle pulse: timeout flush occurred.
- o_overflow  out  1  sticky: a byte arrived while its lane FIFO was full.
- o_count  out  COUNT_WIDTH  number of samples handed off, wraps.

Behaviour:
- Reset values:
  - All outputs 0 except o_ready_l/o_ready_h, which are 1 one cycle after reset deasserts.
  - FIFOs empty, timeout counter 0, o_overflow cleared.
  - Reset mid-operation discards all buffered bytes and any pending sample.
- Lane FIFOs:
  - One per lane, DEPTH entries.
  - Push when i_valid_x && o_ready_x.
  - o_ready_x = !full_x; depends only on occupancy, not on a same-cycle pop, so a full FIFO never accepts, even while popping.
  - i_valid_x while full: byte dropped, o_overflow set until reset.
- Pairing:
  - Output register is free when !o_valid || i_ready.
  - When both FIFOs are non-empty and the output register is free: pop one entry from each lane and load o_sample = {h[SAMPLE_SIZE-DATA_SIZE-1:0], l}. o_valid = 1 from the next edge.
  - Latency: the second byte of a pair written at edge N produces o_valid at edge N+1 (both FIFOs previously empty, output free).
  - Throughput: one sample per cycle with i_ready held high.
  - If the popped high byte has bits [DATA_SIZE-1:SAMPLE_SIZE-DATA_SIZE] ≠ 0: pulse o_format_err in the same cycle o_valid rises; the sample is still delivered.
- Output handshake:
  - o_valid && i_ready: transfer, o_count += 1, wrapping to 0 at 2^COUNT_WIDTH.
  - o_valid && !i_ready: o_sample and o_valid held stable.
- Timeout FSM:
  - States:
    - IDLE: both FIFOs empty or both non-empty; counter 0.
    - WAIT: exactly one FIFO non-empty; counter increments each cycle.
    - FLUSH: single cycle; both FIFOs emptied, o_desync pulsed, returns to IDLE.
  - WAIT→IDLE when the other lane becomes non-empty, or the waiting lane drains; counter cleared.
  - WAIT→FLUSH when the counter reaches TIMEOUT-1.
  - A byte pushed during the FLUSH cycle is discarded.
  - The output register is not affected by a flush.
- Simultaneous push and pop on the same lane in one cycle: legal; occupancy unchanged.

Test Plan:
- Push l=0x34, h=0x12 in the same cycle, i_ready=1 → one cycle later o_valid=1, o_sample=0x1234; o_count=1 after transfer; o_format_err=0.
- Push 10 interleaved pairs back-to-back with i_ready=1 → 10 samples in order, one per cycle after the first; o_count=10; o_overflow=0.
- Push h=0xC5, l=0x00 → o_sample=0x0500; o_format_err pulses exactly once, aligned with o_valid rising.
- Hold i_ready=0; push 5 bytes on the low lane (DEPTH=4) → o_ready_l=0 after 4 accepted bytes; 5th byte dropped, o_overflow=1 and stays 1 until i_reset.
- TIMEOUT=16; push one low byte only → o_desync pulses 16 cycles later; both FIFOs empty; a following pair l=0xAA, h=0x01 yields 0x01AA.
- Assert i_reset while o_valid=1 and the FIFOs are partially full → next cycle o_valid=0, o_count=0, FIFOs empty, no stale sample after release.
